// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchroniser, glitch filter, frame FSM, FWFT FIFO.
// Define PS2_KEY_EVENT_EN to fold E0/F0 prefixes into per-entry ext/release flags.
module ps2_keyboard_rx #(
    parameter int C_filter         = 8,
    parameter int C_timeout_cycles = 5000,
    parameter int C_fifo_abits     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] out_data,
    output logic       out_ext,
    output logic       out_release,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int DEPTH = 1 << C_fifo_abits;
    localparam int TW    = $clog2(C_timeout_cycles + 1);
    localparam int CW    = C_fifo_abits + 1;

    localparam logic [3:0]    FLT_LAST = 4'(C_filter - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(C_timeout_cycles - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef PS2_KEY_EVENT_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       filt_clk_q, filt_clk_d;
    logic       filt_dat_q, filt_dat_d;
    logic [3:0] fcnt_clk_q, fcnt_clk_d;
    logic [3:0] fcnt_dat_q, fcnt_dat_d;
    logic       fall_q, fall_d;

    // Two-flop synchronisers; lines idle high so reset to 1
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2clk};
            dat_sync_q <= {dat_sync_q[0], ps2data};
        end
    end

    // Saturating filters: flip only after C_filter differing samples in a row
    always_comb begin
        filt_clk_d = filt_clk_q;
        fcnt_clk_d = '0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (fcnt_clk_q == FLT_LAST) begin
                filt_clk_d = ~filt_clk_q;
            end else begin
                fcnt_clk_d = fcnt_clk_q + 4'd1;
            end
        end
        filt_dat_d = filt_dat_q;
        fcnt_dat_d = '0;
        if (dat_sync_q[1] != filt_dat_q) begin
            if (fcnt_dat_q == FLT_LAST) begin
                filt_dat_d = ~filt_dat_q;
            end else begin
                fcnt_dat_d = fcnt_dat_q + 4'd1;
            end
        end
        fall_d = filt_clk_q & ~filt_clk_d;
    end

    // Filter state and the registered falling-edge strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk_q <= 1'b1;
            filt_dat_q <= 1'b1;
            fcnt_clk_q <= '0;
            fcnt_dat_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            filt_clk_q <= filt_clk_d;
            filt_dat_q <= filt_dat_d;
            fcnt_clk_q <= fcnt_clk_d;
            fcnt_dat_q <= fcnt_dat_d;
            fall_q     <= fall_d;
        end
    end

    // ------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    logic          good_s;
    logic          perr_d, perr_q;
    logic          ferr_d, ferr_q;

    assign tmo_hit = (state_q != S_IDLE) && !fall_q && (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition happens in a fall cycle or on timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fall_q && !filt_dat_q) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (fall_q && bitcnt_q == 3'd7) begin
                    state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (fall_q) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tmo_hit || fall_q) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Output and datapath decode for the current state
    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        good_s   = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = tmo_hit;
        if (state_q == S_IDLE || fall_q || tmo_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (fall_q) begin
                    bitcnt_d = '0;
                    ferr_d   = filt_dat_q;
                end
            end
            S_DATA: begin
                if (fall_q) begin
                    shift_d  = {filt_dat_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (fall_q) begin
                    par_d = filt_dat_q;
                end
            end
            S_STOP: begin
                if (fall_q) begin
                    if (!filt_dat_q) begin
                        ferr_d = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        good_s = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Frame datapath registers and error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    // ------------------------------------------------------------
    // Push request, optionally with prefix tracking
    // ------------------------------------------------------------
    logic          push_q, push_d;
    logic [EW-1:0] pdata_q, pdata_d;

`ifdef PS2_KEY_EVENT_EN
    logic ext_q, ext_d;
    logic rel_q, rel_d;

    // E0/F0 only arm flags; any other good byte carries and clears them
    always_comb begin
        ext_d   = ext_q;
        rel_d   = rel_q;
        push_d  = 1'b0;
        pdata_d = pdata_q;
        if (perr_d || ferr_d) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (good_s) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                push_d  = 1'b1;
                pdata_d = {ext_q, rel_q, shift_q};
                ext_d   = 1'b0;
                rel_d   = 1'b0;
            end
        end
    end

    // Prefix flags
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            rel_q <= rel_d;
        end
    end
`else
    // Every good byte is pushed raw
    always_comb begin
        push_d  = good_s;
        pdata_d = good_s ? shift_q : pdata_q;
    end
`endif

    // Push request lands one cycle after the stop fall
    always_ff @(posedge clk) begin
        if (reset) begin
            push_q  <= 1'b0;
            pdata_q <= '0;
        end else begin
            push_q  <= push_d;
            pdata_q <= pdata_d;
        end
    end

    // ------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------
    logic [EW-1:0]           mem_q [DEPTH];
    logic [C_fifo_abits-1:0] wptr_q, wptr_d;
    logic [C_fifo_abits-1:0] rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    full;
    logic                    pop;
    logic                    do_push;
    logic                    ovf_d, ovf_q;
    logic [EW-1:0]           head;

    assign full    = (cnt_q == FULL_CNT);
    assign pop     = out_valid & out_ready;
    assign do_push = push_q & (~full | pop);
    assign ovf_d   = push_q & full & ~pop;

    // Pointer and occupancy update; a simultaneous pop frees the full slot
    always_comb begin
        wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        unique case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO control registers and overflow pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage; contents are never seen while empty so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= pdata_q;
        end
    end

    assign head      = mem_q[rptr_q];
    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? head[7:0] : 8'h00;

`ifdef PS2_KEY_EVENT_EN
    assign out_ext     = out_valid & head[9];
    assign out_release = out_valid & head[8];
`else
    assign out_ext     = 1'b0;
    assign out_release = 1'b0;
`endif

    assign err_parity = perr_q;
    assign err_frame  = ferr_q;
    assign overflow   = ovf_q;

endmodule
